// File: rtl/dmem_responder.sv
// dmem_responder: load/store target with fixed latency, byte-lane access and sign/zero extension.
module dmem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;
  logic        r_wr, r_uns, r_req_err;
  logic [31:0] r_mem [2**(ADDR_WIDTH-2)];
  logic                  w_err, w_fire;
  logic [ADDR_WIDTH-3:0] w_idx;
  logic [31:0]           w_word, w_sh, w_ld, w_wd;
  logic [3:0]            w_be;
  assign req_ready  = r_state == IDLE;
  assign resp_valid = r_state == RESP;
  assign w_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00) || |req_addr[31:ADDR_WIDTH];
  assign w_fire = r_state == BUSY && r_cnt == 4'd0;
  assign w_idx  = r_addr[ADDR_WIDTH-1:2];
  assign w_word = r_mem[w_idx];
  assign w_sh   = w_word >> {r_addr[1:0], 3'b000};
  assign w_ld   = r_size == 2'b00 ? {{24{~r_uns & w_sh[7]}}, w_sh[7:0]} :
                  r_size == 2'b01 ? {{16{~r_uns & w_sh[15]}}, w_sh[15:0]} : w_word;
  assign w_be   = r_size == 2'b00 ? 4'b0001 << r_addr[1:0] :
                  r_size == 2'b01 ? 4'b0011 << r_addr[1:0] : 4'b1111;
  assign w_wd   = r_wdata << {r_addr[1:0], 3'b000};
  // Memory has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && w_fire && r_wr && !r_req_err)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_addr    <= req_addr;
          r_wr      <= req_wr;
          r_size    <= req_size;
          r_uns     <= req_unsigned;
          r_wdata   <= req_wdata;
          r_req_err <= w_err;
          r_cnt     <= 4'(LATENCY - 1);
          r_state   <= BUSY;
        end
        BUSY: if (r_cnt == 4'd0) begin
          resp_rdata <= (r_wr || r_req_err) ? 32'd0 : w_ld;
          resp_err   <= r_req_err;
          r_state    <= RESP;
        end else r_cnt <= r_cnt - 4'd1;
        RESP: if (resp_ready) begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder.
module tb_dmem_responder;
  localparam int LAT = 2;
  logic        clk = 0, rst = 1, req_valid = 0, req_wr = 0, req_unsigned = 0, resp_ready = 1;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata;
  logic [1:0]  req_size = 0;
  logic [32:0] sb_q[$];
  int          checks = 0, failures = 0;
  logic [31:0] held_d;
  logic        held_e;
  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wr(req_wr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    sb_q.push_back({ee, ed});
    req_addr = a; req_wr = wr; req_size = sz; req_unsigned = uns; req_wdata = wd;
    req_valid = 1;
    chk("req_ready_idle", 32'(req_ready), 1);
    tick();
    req_valid = 0;
  endtask
  task automatic wait_resp(input string tag);
    int n = 0;
    logic [32:0] e;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, LAT);
    e = sb_q.pop_front();
    chk({tag, "_rdata"}, resp_rdata, e[31:0]);
    chk({tag, "_err"}, 32'(resp_err), 32'(e[32]));
  endtask
  task automatic finish_resp(input string tag);
    resp_ready = 1;
    tick();
    chk({tag, "_idle"}, {30'd0, req_ready, resp_valid}, 32'b10);
  endtask
  task automatic txn(input string tag, input logic [31:0] a, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    issue(a, wr, sz, uns, wd, ed, ee);
    wait_resp(tag);
    finish_resp(tag);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_state", {req_ready, resp_valid, resp_err, resp_rdata}, {3'b100, 32'd0});
    rst = 0;
    tick();
    txn("sw_100", 32'h100, 1, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0);
    txn("lw_100a", 32'h100, 0, 2'b10, 0, 0, 32'hDEADBEEF, 0);
    txn("sb_103", 32'h103, 1, 2'b00, 0, 32'h80, 32'h0, 0);
    txn("lb_103", 32'h103, 0, 2'b00, 0, 0, 32'hFFFFFF80, 0);
    txn("lbu_103", 32'h103, 0, 2'b00, 1, 0, 32'h00000080, 0);
    txn("lw_100b", 32'h100, 0, 2'b10, 0, 0, 32'h80ADBEEF, 0);
    txn("sh_102", 32'h102, 1, 2'b01, 0, 32'h8001, 32'h0, 0);
    txn("lh_102", 32'h102, 0, 2'b01, 0, 0, 32'hFFFF8001, 0);
    txn("lhu_102", 32'h102, 0, 2'b01, 1, 0, 32'h00008001, 0);
    txn("lw_100c", 32'h100, 0, 2'b10, 0, 0, 32'h8001BEEF, 0);
    txn("lb_101", 32'h101, 0, 2'b00, 0, 0, 32'hFFFFFFBE, 0);
    txn("lw_mis", 32'h102, 0, 2'b10, 0, 0, 32'h0, 1);
    txn("sh_mis", 32'h101, 1, 2'b01, 0, 32'hFFFF, 32'h0, 1);
    txn("size11", 32'h100, 0, 2'b11, 0, 0, 32'h0, 1);
    txn("lw_oor", 32'h1000, 0, 2'b10, 0, 0, 32'h0, 1);
    txn("sw_oor", 32'h80000100, 1, 2'b10, 0, 32'h11111111, 32'h0, 1);
    txn("lw_100d", 32'h100, 0, 2'b10, 0, 0, 32'h8001BEEF, 0);
    resp_ready = 0;
    issue(32'h100, 0, 2'b10, 0, 0, 32'h8001BEEF, 0);
    wait_resp("bp");
    held_d = resp_rdata;
    held_e = resp_err;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_ctl", {30'd0, req_ready, resp_valid}, 32'b01);
      chk("bp_hold_data", resp_rdata, held_d);
      chk("bp_hold_err", 32'(resp_err), 32'(held_e));
    end
    finish_resp("bp");
    txn("sw_200z", 32'h200, 1, 2'b10, 0, 32'h0, 32'h0, 0);
    issue(32'h200, 1, 2'b10, 0, 32'h12345678, 32'h0, 0);
    void'(sb_q.pop_back());
    rst = 1;
    tick();
    rst = 0;
    chk("rst_busy", {req_ready, resp_valid, resp_err, resp_rdata}, {3'b100, 32'd0});
    tick();
    chk("rst_quiet", {30'd0, req_ready, resp_valid}, 32'b10);
    txn("lw_200", 32'h200, 0, 2'b10, 0, 0, 32'h0, 0);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
